// File: rtl/refill_randomizer_mc.sv
// refill_randomizer_mc: multi-channel full-flag filter.
// Flag assertion passes through with no delay. Flag release is held off by a
// pseudo-random number of cycles taken from one shared Fibonacci LFSR. Each
// channel reads a different rotation of the LFSR, so channels that release in
// the same cycle get different delays. enable=0 bypasses the filter.
module refill_randomizer_mc #(
    parameter int CHANNELS   = 4,
    parameter int BITS       = 7,
    parameter int DBITS      = 6,
    parameter int MIN_DELAY  = 1,
    parameter int RESET_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                load_seed,
    input  logic [BITS-1:0]     seed,
    input  logic [CHANNELS-1:0] full_in,
    output logic [CHANNELS-1:0] full_out,
    output logic [CHANNELS-1:0] holding
);

    // Wide enough that MIN_DELAY plus the largest random draw never wraps.
    localparam int CW = ((DBITS > 8) ? DBITS : 8) + 1;

    localparam logic [15:0] TAPS16 =
        (BITS == 5)  ? 16'h0014 :
        (BITS == 7)  ? 16'h0041 :
        (BITS == 9)  ? 16'h0110 :
        (BITS == 11) ? 16'h0500 :
        (BITS == 15) ? 16'h6000 :
                       16'hD008;
    localparam logic [BITS-1:0] TAPS  = TAPS16[BITS-1:0];
    localparam logic [CW-1:0]   MIN_W = CW'(MIN_DELAY);
    localparam logic [CW-1:0]   RST_W = CW'(RESET_HOLD);
    localparam logic [BITS-1:0] ONE_W = BITS'(1);

    generate
        if (!(BITS == 5 || BITS == 7 || BITS == 9 || BITS == 11 || BITS == 15 || BITS == 16)
            || DBITS < 1 || DBITS > BITS) begin : g_bad_param
            $error("refill_randomizer_mc: unsupported BITS/DBITS combination");
        end
    endgenerate

    logic [BITS-1:0]     lfsr_q, lfsr_d;
    logic [CHANNELS-1:0] full_last_q, full_last_d;
    logic [CW-1:0]       count_q [CHANNELS];
    logic [CW-1:0]       count_d [CHANNELS];
    logic [DBITS-1:0]    rnd     [CHANNELS];
    logic [CHANNELS-1:0] busy;

    // Per-channel random draw: low DBITS of the LFSR rotated left by channel index.
    generate
        for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_rnd
            localparam int ROT = ch % BITS;
            assign rnd[ch] = DBITS'({lfsr_q, lfsr_q} >> (BITS - ROT));
        end
    endgenerate

    // LFSR next state: seed load wins over stepping; a zero seed becomes 1.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load_seed) begin
            lfsr_d = (seed == '0) ? ONE_W : seed;
        end else if (enable) begin
            lfsr_d = {lfsr_q[BITS-2:0], ^(lfsr_q & TAPS)};
        end
    end

    // Per-channel hold counters: clear on assertion, load on release, count down.
    always_comb begin
        full_last_d = full_in;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            count_d[ch] = '0;
            if (enable && !full_in[ch]) begin
                if (full_last_q[ch]) begin
                    // A release that finds a running count can only be the first
                    // cycle after reset; keep the reset hold instead of redrawing.
                    if (count_q[ch] != '0) begin
                        count_d[ch] = count_q[ch];
                    end else begin
                        count_d[ch] = MIN_W + CW'(rnd[ch]);
                    end
                end else if (count_q[ch] != '0) begin
                    count_d[ch] = count_q[ch] - CW'(1);
                end
            end
        end
    end

    // Outputs: assertion is combinational from full_in, release follows the hold.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            busy[ch] = (count_q[ch] != '0);
        end
        if (rst) begin
            full_out = '1;
        end else if (enable) begin
            full_out = full_in | full_last_q | busy;
        end else begin
            full_out = full_in;
        end
        // full_last covers the release cycle itself, so holding starts the cycle after.
        holding = enable ? (busy & ~full_last_q) : '0;
    end

    // State registers with synchronous reset into the post-reset hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q      <= ONE_W;
            full_last_q <= '1;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                count_q[ch] <= RST_W;
            end
        end else begin
            lfsr_q      <= lfsr_d;
            full_last_q <= full_last_d;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                count_q[ch] <= count_d[ch];
            end
        end
    end

endmodule
